// File: rtl/cmd_slave.sv
// Four-phase command slave: accumulator ALU plus a 4-entry register file.
// The command is latched in IDLE, executed in EXEC and acknowledged in RESP.
module cmd_slave #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [2:0]       c,
  input  logic [WIDTH-1:0] din,
  output logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_STORE = 3'b110,
    OP_FETCH = 3'b111
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] rf [4];

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_next;
  logic             carry_next;
  logic             rf_we;

  // Extra top bit of the widened difference is the borrow, i.e. a < opnd.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, opnd};
    diff       = {1'b0, a} - {1'b0, opnd};
    a_next     = a;
    carry_next = carry;
    rf_we      = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_LOAD:  a_next = opnd;
      OP_ADD:   {carry_next, a_next} = sum;
      OP_SUB:   {carry_next, a_next} = diff;
      OP_SHL: begin
        carry_next = a[WIDTH-1];
        a_next     = {a[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_next = a[0];
        a_next     = {1'b0, a[WIDTH-1:1]};
      end
      OP_STORE: rf_we  = 1'b1;
      OP_FETCH: a_next = rf[opnd[1:0]];
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_NOP;
      opnd  <= '0;
      a     <= '0;
      carry <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            op    <= op_t'(c);
            opnd  <= din;
            state <= EXEC;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        EXEC: begin
          a     <= a_next;
          carry <= carry_next;
          if (rf_we) rf[opnd[1:0]] <= a;
          state <= RESP;
          ack   <= 1'b1;
          busy  <= 1'b1;
        end
        RESP: begin
          // Hold the response until the master withdraws req.
          if (req) begin
            ack  <= 1'b1;
            busy <= 1'b1;
          end else begin
            state <= IDLE;
            ack   <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = a;

endmodule

// File: tb/tb_cmd_slave.sv
// Self-checking bench for cmd_slave: expected results queued at issue, checked at ack.
module tb_cmd_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] c;
  logic [7:0] din;
  logic       ack;
  logic [7:0] dout;
  logic       carry;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];

  cmd_slave #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .c     (c),
    .din   (din),
    .ack   (ack),
    .dout  (dout),
    .carry (carry),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011,
                         SHL = 3'b100, SHR = 3'b101, STORE = 3'b110, FETCH = 3'b111;

  // Issue one command, check latency, scoreboard result, hold behaviour and release.
  task automatic send(input string name, input logic [2:0] op, input logic [7:0] d,
                      input logic [7:0] ed, input logic ec, input int hold);
    int lat;
    logic [8:0] e;
    exp_q.push_back({ed, ec});
    @(negedge clk);
    req = 1'b1; c = op; din = d;
    @(negedge clk);
    lat = 1;
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s exec: ack=%b busy=%b, expected ack=0 busy=1", name, ack, busy);
    end
    while (ack !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL %s latency: ack after %0d edges, expected 2", name, lat);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({dout, carry} !== e) begin
      n_fail++;
      $display("FAIL %s result: dout=%h carry=%b, expected dout=%h carry=%b",
               name, dout, carry, e[8:1], e[0]);
    end
    for (int i = 0; i < hold; i++) begin
      c = 3'($urandom); din = 8'($urandom);
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1 || dout !== e[8:1]) begin
        n_fail++;
        $display("FAIL %s hold%0d: ack=%b dout=%h, expected ack=1 dout=%h",
                 name, i, ack, dout, e[8:1]);
      end
    end
    req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || dout !== e[8:1]) begin
      n_fail++;
      $display("FAIL %s release: ack=%b busy=%b dout=%h, expected 0 0 %h",
               name, ack, busy, dout, e[8:1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; c = 3'b000; din = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack, busy, dout, carry} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset: ack=%b busy=%b dout=%h carry=%b, expected all 0",
               ack, busy, dout, carry);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    send("load_3c", LOAD, 8'h3C, 8'h3C, 1'b0, 0);
    send("add_d0",  ADD,  8'hD0, 8'h0C, 1'b1, 0);
  endtask

  task automatic test_sub();
    send("load_05", LOAD, 8'h05, 8'h05, 1'b1, 0);
    send("sub_06",  SUB,  8'h06, 8'hFF, 1'b1, 0);
    send("sub_0f",  SUB,  8'h0F, 8'hF0, 1'b0, 0);
  endtask

  task automatic test_shift();
    send("load_81", LOAD, 8'h81, 8'h81, 1'b0, 0);
    send("shl",     SHL,  8'hFF, 8'h02, 1'b1, 0);
    send("shr",     SHR,  8'hFF, 8'h01, 1'b0, 0);
  endtask

  task automatic test_regfile();
    send("load_5a", LOAD,  8'h5A, 8'h5A, 1'b0, 0);
    send("store_2", STORE, 8'h02, 8'h5A, 1'b0, 0);
    send("load_00", LOAD,  8'h00, 8'h00, 1'b0, 0);
    send("fetch_2", FETCH, 8'h02, 8'h5A, 1'b0, 0);
    send("fetch_1", FETCH, 8'h01, 8'h00, 1'b0, 0);
    send("nop",     NOP,   8'hFF, 8'h00, 1'b0, 0);
  endtask

  task automatic test_hold();
    send("add_hold", ADD, 8'h01, 8'h01, 1'b0, 10);
  endtask

  task automatic test_req_drop();
    int acks = 0;
    @(negedge clk);
    req = 1'b1; c = ADD; din = 8'h01;
    @(negedge clk);
    req = 1'b0; c = LOAD; din = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 1 || dout !== 8'h02 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: ack cycles=%0d dout=%h busy=%b, expected 1 02 0",
               acks, dout, busy);
    end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    @(negedge clk);
    req = 1'b1; c = ADD; din = 8'h10;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_state: ack=%b busy=%b dout=%h, expected 0 0 00", ack, busy, dout);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_ack: ack cycles=%0d dout=%h, expected 0 00", acks, dout);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_regfile();
    test_hold();
    test_req_drop();
    test_reset_abort();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d results left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
